// File: rtl/lc2k_multicycle_ctrl.sv
// Multi-cycle control FSM for the LC2K CPU.
// Sequences FETCH/DECODE/EXEC/MEM/WB for each instruction and waits on the
// mem_req/mem_ack handshake. Drives every datapath select and write enable,
// counts retired instructions with saturation, and holds a sticky halt.
module lc2k_multicycle_ctrl #(
    parameter int DATA_W     = 32,
    parameter int OPCODE_LSB = 22,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] instr,
    input  logic              mem_ack,
    input  logic              alu_eq,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_addr_sel,
    output logic              ir_we,
    output logic              alu_b_sel,
    output logic [1:0]        alu_op,
    output logic              reg_we,
    output logic              reg_dst_sel,
    output logic [1:0]        wb_sel,
    output logic              pc_we,
    output logic [1:0]        pc_sel,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_NOR  = 3'd1,
        OP_LW   = 3'd2,
        OP_SW   = 3'd3,
        OP_BEQ  = 3'd4,
        OP_JALR = 3'd5,
        OP_HALT = 3'd6,
        OP_NOOP = 3'd7
    } opcode_t;

    state_t  state_q, state_d;
    opcode_t opcode_q;
    logic    retire;

    // Only the opcode field is consumed; the rest of the word belongs to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr;

    // State register, latched opcode and saturating retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            opcode_q    <= OP_ADD;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (ir_we) begin
                opcode_q <= opcode_t'(instr[OPCODE_LSB+2:OPCODE_LSB]);
            end
            if (retire && (instr_count != '1)) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    // Next-state and output decode from state, latched opcode and mem_ack/alu_eq.
    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        alu_b_sel    = 1'b0;
        alu_op       = 2'd0;
        reg_we       = 1'b0;
        reg_dst_sel  = 1'b0;
        wb_sel       = 2'd0;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        busy         = 1'b1;
        halted       = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                case (opcode_q)
                    OP_JALR: state_d = S_WB;
                    OP_NOOP: begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_HALT: begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_HALT;
                    end
                    default: state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                case (opcode_q)
                    OP_ADD: begin
                        alu_b_sel = 1'b1;
                        state_d   = S_WB;
                    end
                    OP_NOR: begin
                        alu_b_sel = 1'b1;
                        alu_op    = 2'd1;
                        state_d   = S_WB;
                    end
                    OP_BEQ: begin
                        alu_b_sel = 1'b1;
                        alu_op    = 2'd2;
                        pc_we     = 1'b1;
                        pc_sel    = alu_eq ? 2'd1 : 2'd0;
                        retire    = 1'b1;
                        state_d   = S_FETCH;
                    end
                    default: state_d = S_MEM;
                endcase
            end

            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode_q == OP_SW);
                if (mem_ack) begin
                    if (opcode_q == OP_SW) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
                case (opcode_q)
                    OP_ADD, OP_NOR: begin
                        reg_dst_sel = 1'b1;
                        wb_sel      = 2'd1;
                        alu_b_sel   = 1'b1;
                        alu_op      = (opcode_q == OP_NOR) ? 2'd1 : 2'd0;
                    end
                    OP_JALR: begin
                        wb_sel = 2'd2;
                        pc_sel = 2'd2;
                    end
                    default: ;
                endcase
            end

            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end

            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lc2k_multicycle_ctrl.sv
// Scoreboard bench for lc2k_multicycle_ctrl: stimulus pushes hand-derived
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_lc2k_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] instr = '0;
    logic        mem_ack = 1'b0;
    logic        alu_eq = 1'b0;

    logic        mem_req, mem_we, mem_addr_sel, ir_we, alu_b_sel;
    logic [1:0]  alu_op;
    logic        reg_we, reg_dst_sel;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        busy, halted;
    logic [31:0] instr_count;

    logic        m4_req, m4_we, m4_as, m4_ir, m4_bs, m4_rwe, m4_rds, m4_pcwe, m4_busy, m4_halt;
    logic [1:0]  m4_aop, m4_wbs, m4_pcs;
    logic [3:0]  cnt4;

    lc2k_multicycle_ctrl #(.DATA_W(32), .OPCODE_LSB(22), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .mem_ack(mem_ack),
        .alu_eq(alu_eq), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_we(ir_we), .alu_b_sel(alu_b_sel), .alu_op(alu_op), .reg_we(reg_we),
        .reg_dst_sel(reg_dst_sel), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
        .busy(busy), .halted(halted), .instr_count(instr_count)
    );

    lc2k_multicycle_ctrl #(.DATA_W(32), .OPCODE_LSB(22), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .mem_ack(mem_ack),
        .alu_eq(alu_eq), .mem_req(m4_req), .mem_we(m4_we), .mem_addr_sel(m4_as),
        .ir_we(m4_ir), .alu_b_sel(m4_bs), .alu_op(m4_aop), .reg_we(m4_rwe),
        .reg_dst_sel(m4_rds), .wb_sel(m4_wbs), .pc_we(m4_pcwe), .pc_sel(m4_pcs),
        .busy(m4_busy), .halted(m4_halt), .instr_count(cnt4)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] ctl;
        int unsigned cnt;
        int unsigned cnt4;
    } exp_t;

    exp_t        sb[$];
    int unsigned compared = 0;
    int unsigned mismatched = 0;
    int unsigned retired = 0;

    // Field order: mem_req mem_we mem_addr_sel ir_we alu_b_sel alu_op reg_we reg_dst_sel wb_sel pc_we pc_sel busy halted
    function automatic logic [15:0] mk(input logic mreq, input logic mwe, input logic mas,
                                       input logic irwe, input logic absel, input logic [1:0] aop,
                                       input logic rwe, input logic rds, input logic [1:0] wbs,
                                       input logic pcwe, input logic [1:0] pcs,
                                       input logic bsy, input logic hlt);
        return {mreq, mwe, mas, irwe, absel, aop, rwe, rds, wbs, pcwe, pcs, bsy, hlt};
    endfunction

    logic [15:0] act_ctl;
    assign act_ctl = {mem_req, mem_we, mem_addr_sel, ir_we, alu_b_sel, alu_op, reg_we,
                      reg_dst_sel, wb_sel, pc_we, pc_sel, busy, halted};

    // Monitor: compare every pending expectation away from the rising edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            compared++;
            if (act_ctl !== e.ctl) begin
                mismatched++;
                $display("FAIL %s ctl: got %b want %b", e.name, act_ctl, e.ctl);
            end
            compared++;
            if (instr_count !== e.cnt) begin
                mismatched++;
                $display("FAIL %s instr_count: got %0d want %0d", e.name, instr_count, e.cnt);
            end
            compared++;
            if (cnt4 !== e.cnt4[3:0]) begin
                mismatched++;
                $display("FAIL %s instr_count(CNT_W=4): got %0d want %0d", e.name, cnt4, e.cnt4);
            end
        end
    end

    logic [15:0] C_IDLE, C_F_ACK, C_F_WAIT, C_DEC, C_DEC_RET, C_EX_ADD, C_EX_NOR;
    logic [15:0] C_EX_BEQ_T, C_EX_BEQ_N, C_MEM_RD, C_MEM_WR, C_MEM_WR_ACK;
    logic [15:0] C_WB_ADD, C_WB_NOR, C_WB_LW, C_WB_JALR, C_HALT;

    function automatic int unsigned sat4(input int unsigned v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic push(input string nm, input logic [15:0] c);
        sb.push_back('{nm, c, retired, sat4(retired)});
    endtask

    // One clock cycle of stimulus plus the expected outputs for that cycle.
    task automatic cyc(input string nm, input logic st, input logic [2:0] op, input logic ack,
                       input logic eq, input logic [15:0] c, input bit ret);
        @(posedge clk);
        #1;
        start   = st;
        instr   = {7'd0, op, 22'h15A5A5};
        mem_ack = ack;
        alu_eq  = eq;
        push(nm, c);
        if (ret) retired++;
    endtask

    task automatic do_reset(input string nm);
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        start   = 1'b0;
        mem_ack = 1'b0;
        retired = 0;
        push({nm, " asserted"}, C_IDLE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push({nm, " released"}, C_IDLE);
    endtask

    localparam logic [2:0] ADD = 3'd0, NOR = 3'd1, LW = 3'd2, SW = 3'd3,
                           BEQ = 3'd4, JALR = 3'd5, HALT = 3'd6, NOOP = 3'd7;

    initial begin
        //             req we as ir bs aop  rwe rds wbs  pcwe pcs  bsy hlt
        C_IDLE       = mk(0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0);
        C_F_ACK      = mk(1, 0, 0, 1, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 0);
        C_F_WAIT     = mk(1, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 0);
        C_DEC        = mk(0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 0);
        C_DEC_RET    = mk(0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 1, 2'd0, 1, 0);
        C_EX_ADD     = mk(0, 0, 0, 0, 1, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 0);
        C_EX_NOR     = mk(0, 0, 0, 0, 1, 2'd1, 0, 0, 2'd0, 0, 2'd0, 1, 0);
        C_EX_BEQ_T   = mk(0, 0, 0, 0, 1, 2'd2, 0, 0, 2'd0, 1, 2'd1, 1, 0);
        C_EX_BEQ_N   = mk(0, 0, 0, 0, 1, 2'd2, 0, 0, 2'd0, 1, 2'd0, 1, 0);
        C_MEM_RD     = mk(1, 0, 1, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 0);
        C_MEM_WR     = mk(1, 1, 1, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 0);
        C_MEM_WR_ACK = mk(1, 1, 1, 0, 0, 2'd0, 0, 0, 2'd0, 1, 2'd0, 1, 0);
        C_WB_ADD     = mk(0, 0, 0, 0, 1, 2'd0, 1, 1, 2'd1, 1, 2'd0, 1, 0);
        C_WB_NOR     = mk(0, 0, 0, 0, 1, 2'd1, 1, 1, 2'd1, 1, 2'd0, 1, 0);
        C_WB_LW      = mk(0, 0, 0, 0, 0, 2'd0, 1, 0, 2'd0, 1, 2'd0, 1, 0);
        C_WB_JALR    = mk(0, 0, 0, 0, 0, 2'd0, 1, 0, 2'd2, 1, 2'd2, 1, 0);
        C_HALT       = mk(0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 0, 1);

        do_reset("t1 reset");

        // add with zero-wait memory
        cyc("t1 idle start", 1, ADD, 1, 0, C_IDLE,   0);
        cyc("t1 fetch",      0, ADD, 1, 0, C_F_ACK,  0);
        cyc("t1 decode",     0, NOOP, 1, 0, C_DEC,   0);
        cyc("t1 exec",       0, NOOP, 1, 0, C_EX_ADD, 0);
        cyc("t1 wb",         1, NOOP, 1, 0, C_WB_ADD, 1);

        // lw with three memory wait cycles
        cyc("t2 fetch",      0, LW, 1, 0, C_F_ACK,  0);
        cyc("t2 decode",     0, ADD, 1, 0, C_DEC,   0);
        cyc("t2 exec",       0, ADD, 0, 0, C_DEC,   0);
        cyc("t2 mem wait1",  0, ADD, 0, 0, C_MEM_RD, 0);
        cyc("t2 mem wait2",  0, ADD, 0, 0, C_MEM_RD, 0);
        cyc("t2 mem wait3",  0, ADD, 0, 0, C_MEM_RD, 0);
        cyc("t2 mem ack",    0, ADD, 1, 0, C_MEM_RD, 0);
        cyc("t2 wb",         0, ADD, 1, 0, C_WB_LW,  1);

        // nor with one fetch wait cycle
        cyc("nor fetch wait", 0, NOR, 0, 0, C_F_WAIT, 0);
        cyc("nor fetch",      0, NOR, 1, 0, C_F_ACK,  0);
        cyc("nor decode",     0, ADD, 1, 0, C_DEC,    0);
        cyc("nor exec",       0, ADD, 1, 0, C_EX_NOR, 0);
        cyc("nor wb",         0, ADD, 1, 0, C_WB_NOR, 1);

        // beq taken and not taken
        cyc("t3 fetch eq",    0, BEQ, 1, 0, C_F_ACK,    0);
        cyc("t3 decode eq",   0, ADD, 1, 0, C_DEC,      0);
        cyc("t3 exec eq",     0, ADD, 1, 1, C_EX_BEQ_T, 1);
        cyc("t3 fetch ne",    0, BEQ, 1, 1, C_F_ACK,    0);
        cyc("t3 decode ne",   0, ADD, 1, 1, C_DEC,      0);
        cyc("t3 exec ne",     0, ADD, 1, 0, C_EX_BEQ_N, 1);

        // sw with one memory wait cycle
        cyc("sw fetch",       0, SW, 1, 0, C_F_ACK,      0);
        cyc("sw decode",      0, ADD, 1, 0, C_DEC,       0);
        cyc("sw exec",        0, ADD, 0, 0, C_DEC,       0);
        cyc("sw mem wait",    0, ADD, 0, 0, C_MEM_WR,    0);
        cyc("sw mem ack",     0, ADD, 1, 0, C_MEM_WR_ACK, 1);
        cyc("sw next fetch",  0, ADD, 0, 0, C_F_WAIT,    0);

        // jalr then halt from a fresh reset
        do_reset("t4 reset");
        cyc("t4 idle start",   1, JALR, 1, 0, C_IDLE,    0);
        cyc("t4 jalr fetch",   0, JALR, 1, 0, C_F_ACK,   0);
        cyc("t4 jalr decode",  0, ADD,  1, 0, C_DEC,     0);
        cyc("t4 jalr wb",      0, ADD,  1, 0, C_WB_JALR, 1);
        cyc("t4 halt fetch",   0, HALT, 1, 0, C_F_ACK,   0);
        cyc("t4 halt decode",  0, ADD,  1, 0, C_DEC_RET, 1);
        cyc("t4 halted 1",     1, ADD,  1, 0, C_HALT,    0);
        cyc("t4 halted 2",     1, ADD,  1, 0, C_HALT,    0);
        cyc("t4 halted 3",     0, ADD,  1, 0, C_HALT,    0);

        // 17 noops: 4-bit counter saturates at 15
        do_reset("t5 reset");
        cyc("t5 idle start", 1, NOOP, 1, 0, C_IDLE, 0);
        for (int i = 0; i < 17; i++) begin
            cyc($sformatf("t5 noop%0d fetch", i),  0, NOOP, 1, 0, C_F_ACK,   0);
            cyc($sformatf("t5 noop%0d decode", i), 0, ADD,  1, 0, C_DEC_RET, 1);
        end
        cyc("t5 after", 0, NOOP, 0, 0, C_F_WAIT, 0);

        // asynchronous reset in the middle of an sw memory access
        do_reset("t6 reset");
        cyc("t6 idle start", 1, SW, 1, 0, C_IDLE,  0);
        cyc("t6 fetch",      0, SW, 1, 0, C_F_ACK, 0);
        cyc("t6 decode",     0, ADD, 1, 0, C_DEC,  0);
        cyc("t6 exec",       0, ADD, 0, 0, C_DEC,  0);
        cyc("t6 mem wait",   0, ADD, 0, 0, C_MEM_WR, 0);
        @(posedge clk);
        #3;
        rst_n   = 1'b0;
        retired = 0;
        push("t6 async reset", C_IDLE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ack = 1'b1;
        push("t6 released", C_IDLE);
        cyc("t6 idle hold1", 0, SW, 1, 0, C_IDLE, 0);
        cyc("t6 idle hold2", 0, SW, 1, 0, C_IDLE, 0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
